vnu: RTL

VNU -- requirements
Module: vnu

---
 rtl/vnu.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/vnu.sv
// -----------------------------------------------------------------------------
// vnu -- LDPC variable-node update unit.
//
// Accepts one channel LLR followed by DV check-to-variable messages (one per
// beat, index order 0..DV-1), then produces DV variable-to-check messages as
// one bundle: q[i] = sat(llr + sum(r) - r[i]). The hard decision is the sign
// of the full sum.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   en         global enable; low freezes all state and gates handshakes
//   llr_valid  channel LLR offered
//   llr        signed channel LLR (data_w)
//   llr_ready  LLR may be accepted (IDLE and en)
//   r_valid    check-to-variable message offered
//   r          signed check-to-variable message (data_w)
//   r_ready    message may be accepted (ACC and en)
//   q_valid    output bundle valid (OUT)
//   q          DV messages, slice i is q[i*data_w +: data_w]
//   q_ready    consumer accepts the bundle
//   hard       hard decision, 1 when the total is negative
//
// Handshake: a transfer happens on a rising edge where valid, ready and en
// are all high. Ready/valid outputs are functions of state and en only, so
// none of them depends combinationally on its partner's valid/ready.
// -----------------------------------------------------------------------------
module vnu #(
    parameter int DV     = 3,
    parameter int data_w = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   llr_valid,
    input  logic [data_w-1:0]      llr,
    output logic                   llr_ready,
    input  logic                   r_valid,
    input  logic [data_w-1:0]      r,
    output logic                   r_ready,
    output logic                   q_valid,
    output logic [data_w*DV-1:0]   q,
    input  logic                   q_ready,
    output logic                   hard
);

    localparam int idx_w = $clog2(DV + 1);
    localparam int sum_w = data_w + idx_w + 1;

    // Symmetric saturation bounds, held at sum_w+1 bits to match the
    // difference width.
    localparam logic signed [sum_w:0] sat_max =
        $signed({{(sum_w - data_w + 2){1'b0}}, {(data_w - 1){1'b1}}});
    localparam logic signed [sum_w:0] sat_min = -sat_max;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                     state;
    state_t                     next_state;
    logic [idx_w-1:0]           cnt;
    logic signed [sum_w-1:0]    total;
    logic [data_w-1:0]          buffer [DV];
    logic signed [sum_w:0]      diff [DV];
    logic [data_w*DV-1:0]       q_calc;

    logic llr_xfer;
    logic r_xfer;
    logic q_xfer;
    logic last_r;

    assign llr_xfer = llr_valid & llr_ready;
    assign r_xfer   = r_valid & r_ready;
    assign q_xfer   = q_valid & q_ready & en;
    assign last_r   = (cnt == idx_w'(DV - 1));

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        llr_ready  = 1'b0;
        r_ready    = 1'b0;
        q_valid    = 1'b0;
        case (state)
            IDLE: begin
                llr_ready = en;
                if (llr_xfer) begin
                    next_state = ACC;
                end
            end
            ACC: begin
                r_ready = en;
                if (r_xfer && last_r) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                next_state = OUT;
            end
            OUT: begin
                // The exit edge lands in IDLE, so the next LLR is taken no
                // earlier than one edge later.
                q_valid = 1'b1;
                if (q_xfer) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Extrinsic messages: total minus own input, clipped symmetrically so the
    // most negative code never appears on q.
    // -------------------------------------------------------------------------
    always_comb begin
        q_calc = '0;
        for (int i = 0; i < DV; i++) begin
            diff[i] = $signed({total[sum_w-1], total})
                    - $signed({{(sum_w + 1 - data_w){buffer[i][data_w-1]}}, buffer[i]});
            if (diff[i] > sat_max) begin
                q_calc[i*data_w +: data_w] = sat_max[data_w-1:0];
            end else if (diff[i] < sat_min) begin
                q_calc[i*data_w +: data_w] = sat_min[data_w-1:0];
            end else begin
                q_calc[i*data_w +: data_w] = diff[i][data_w-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            total <= '0;
            q     <= '0;
            hard  <= 1'b0;
            for (int i = 0; i < DV; i++) begin
                buffer[i] <= '0;
            end
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (llr_xfer) begin
                        total <= $signed({{(sum_w - data_w){llr[data_w-1]}}, llr});
                        cnt   <= '0;
                    end
                end
                ACC: begin
                    if (r_xfer) begin
                        for (int i = 0; i < DV; i++) begin
                            if (cnt == idx_w'(i)) begin
                                buffer[i] <= r;
                            end
                        end
                        // sum_w leaves headroom for llr plus DV messages.
                        total <= total + $signed({{(sum_w - data_w){r[data_w-1]}}, r});
                        cnt   <= cnt + idx_w'(1);
                    end
                end
                CALC: begin
                    q    <= q_calc;
                    hard <= total[sum_w-1];
                end
                default: begin
                end
            endcase
        end
    end

endmodule
